// File: rtl/pwm_deadtime_gen.sv
// pwm_deadtime_gen
// Compares the carrier against a shadowed compare value and drives a
// complementary high/low gate pair with a programmable dead-time gap.
// A trip input forces both outputs off and is latched until enable drops.
//
// state   | meaning
// --------+------------------------------------------------------------
// OFF     | both outputs low; waits for enable with no latched trip
// DT_H    | dead-time gap, both low; heading toward the high side
// H_ON    | high-side gate on
// DT_L    | dead-time gap, both low; heading toward the low side
// L_ON    | low-side gate on
//
// A gap exits to whichever side the reference asks for when the count
// expires, so a DT_H interval may end in L_ON if the duty moved meanwhile.
module pwm_deadtime_gen #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] carrier,
    input  logic             mask_event,
    input  logic [WIDTH-1:0] compare,
    input  logic [WIDTH-1:0] dead_time,
    input  logic             enable,
    input  logic             trip,
    output logic             pwm_h,
    output logic             pwm_l,
    output logic [WIDTH-1:0] cmp_active,
    output logic             tripped
);

    localparam logic [2:0] ST_OFF  = 3'd0;
    localparam logic [2:0] ST_DT_H = 3'd1;
    localparam logic [2:0] ST_H_ON = 3'd2;
    localparam logic [2:0] ST_DT_L = 3'd3;
    localparam logic [2:0] ST_L_ON = 3'd4;

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] r_cmp;
    logic             r_ref_q;
    logic             r_tripped;
    logic             w_tripped_nxt;
    logic             w_dt_zero;
    logic [WIDTH-1:0] w_dt_load;

    // The counter holds "remaining gap cycles minus one", so a load of
    // dead_time-1 yields exactly dead_time cycles with both outputs low.
    assign w_dt_zero = (dead_time == '0);
    assign w_dt_load = dead_time - WIDTH'(1);

    // Shadow compare: only reloads on the carrier generator's strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cmp <= '0;
        end else if (mask_event) begin
            r_cmp <= compare;
        end
    end

    // Registered reference: high while the carrier is below the shadow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ref_q <= 1'b0;
        end else begin
            r_ref_q <= (carrier < r_cmp);
        end
    end

    // Next-state logic: trip beats enable, enable beats normal sequencing.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_tripped_nxt = r_tripped;
        if (trip) begin
            w_tripped_nxt = 1'b1;
            w_state_nxt   = ST_OFF;
            w_cnt_nxt     = '0;
        end else if (!enable) begin
            w_tripped_nxt = 1'b0;
            w_state_nxt   = ST_OFF;
            w_cnt_nxt     = '0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    if (!r_tripped) begin
                        if (w_dt_zero) begin
                            w_state_nxt = r_ref_q ? ST_H_ON : ST_L_ON;
                        end else begin
                            w_state_nxt = r_ref_q ? ST_DT_H : ST_DT_L;
                            w_cnt_nxt   = w_dt_load;
                        end
                    end
                end
                ST_H_ON: begin
                    if (!r_ref_q) begin
                        if (w_dt_zero) begin
                            w_state_nxt = ST_L_ON;
                        end else begin
                            w_state_nxt = ST_DT_L;
                            w_cnt_nxt   = w_dt_load;
                        end
                    end
                end
                ST_L_ON: begin
                    if (r_ref_q) begin
                        if (w_dt_zero) begin
                            w_state_nxt = ST_H_ON;
                        end else begin
                            w_state_nxt = ST_DT_H;
                            w_cnt_nxt   = w_dt_load;
                        end
                    end
                end
                ST_DT_H, ST_DT_L: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = r_ref_q ? ST_H_ON : ST_L_ON;
                    end else begin
                        w_cnt_nxt = r_cnt - WIDTH'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_OFF;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State, dead-time counter and sticky trip flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_OFF;
            r_cnt     <= '0;
            r_tripped <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_tripped <= w_tripped_nxt;
        end
    end

    // Moore outputs straight from the state register, so reset clears
    // them asynchronously and they can never be high together.
    assign pwm_h      = (r_state == ST_H_ON);
    assign pwm_l      = (r_state == ST_L_ON);
    assign cmp_active = r_cmp;
    assign tripped    = r_tripped;

endmodule
